pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, flush, memory-wait and halt control for a 5-stage pipeline.
//
// Parameters:
//   MEM_TIMEOUT  MEM_WAIT cycles without mem_ack before fatal error (2..255)
//   DRAIN_CYC    unfrozen cycles to empty EXE/MEM/WB after halt (1..3)
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   src1_ID/src2_ID/ST_src_ID        decode-stage source registers
//   use_src1_ID/use_src2_ID/use_st_ID source actually read
//   dest_EXE, MEM_R_EN_EXE           EXE-stage destination / load flag
//   br_taken_EXE                     taken branch resolved in EXE
//   halt_ID, resume                  HALT in decode / debug restart pulse
//   mem_req_MEM, mem_ack             data-memory handshake
//   stall_IF, stall_ID, bubble_EXE, flush_IF_ID, freeze_pipe  pipeline control
//   halted, mem_err                  status flags
//   stall_cnt, flush_cnt, memwait_cnt performance counters
// Optional feature: define PIPELINE_CTRL_PERF_CNT_EN to build the performance
// counters; otherwise the counter ports are tied to zero.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned DRAIN_CYC   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  src1_ID,
  input  logic [4:0]  src2_ID,
  input  logic [4:0]  ST_src_ID,
  input  logic        use_src1_ID,
  input  logic        use_src2_ID,
  input  logic        use_st_ID,
  input  logic [4:0]  dest_EXE,
  input  logic        MEM_R_EN_EXE,
  input  logic        br_taken_EXE,
  input  logic        halt_ID,
  input  logic        resume,
  input  logic        mem_req_MEM,
  input  logic        mem_ack,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        bubble_EXE,
  output logic        flush_IF_ID,
  output logic        freeze_pipe,
  output logic        halted,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] memwait_cnt
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned DRN_W  = 2;

  typedef enum logic [2:0] {
    S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic                resumed_q, resumed_d;

  logic src_match, load_use, mem_stall;

  // Register 0 is hard-wired, so it never creates a hazard.
  assign src_match = (use_src1_ID && (src1_ID   == dest_EXE)) ||
                     (use_src2_ID && (src2_ID   == dest_EXE)) ||
                     (use_st_ID   && (ST_src_ID == dest_EXE));
  assign load_use  = (state_q == S_RUN) && MEM_R_EN_EXE &&
                     (dest_EXE != 5'd0) && src_match;
  assign mem_stall = mem_req_MEM && !mem_ack;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      wait_q    <= '0;
      drain_q   <= '0;
      resumed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      resumed_q <= resumed_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    drain_d   = drain_q;
    // The HALT that was in ID at resume stays masked until the PC really moves.
    resumed_d = resumed_q && (freeze_pipe || stall_ID);
    unique case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d = S_MEM_WAIT;
          wait_d  = '0;
        end else if (!br_taken_EXE && !load_use && halt_ID && !resumed_q) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          state_d = S_RUN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q + WAIT_W'(1) == WAIT_W'(MEM_TIMEOUT)) state_d = S_ERR;
        end
      end
      S_DRAIN: begin
        // Drain progress pauses while a draining MEM access is frozen.
        if (!mem_stall) begin
          drain_d = drain_q + DRN_W'(1);
          if (drain_q + DRN_W'(1) == DRN_W'(DRAIN_CYC)) state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (resume) begin
          state_d   = S_RUN;
          resumed_d = 1'b1;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_RUN;
    endcase
  end

  // Output decode: freeze > branch flush > load-use.
  always_comb begin
    stall_IF    = 1'b0;
    stall_ID    = 1'b0;
    bubble_EXE  = 1'b0;
    flush_IF_ID = 1'b0;
    freeze_pipe = 1'b0;
    halted      = 1'b0;
    mem_err     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          freeze_pipe = 1'b1;
        end else if (br_taken_EXE) begin
          flush_IF_ID = 1'b1;
          bubble_EXE  = 1'b1;
        end else if (load_use) begin
          stall_IF   = 1'b1;
          stall_ID   = 1'b1;
          bubble_EXE = 1'b1;
        end
      end
      S_MEM_WAIT: freeze_pipe = !mem_ack;
      S_DRAIN, S_HALTED: begin
        halted = (state_q == S_HALTED);
        if (mem_stall) begin
          freeze_pipe = 1'b1;
        end else begin
          stall_IF   = 1'b1;
          stall_ID   = 1'b1;
          bubble_EXE = 1'b1;
        end
      end
      S_ERR: begin
        freeze_pipe = 1'b1;
        mem_err     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  localparam int unsigned CNT_W = 32;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  // Saturating event counters; stall_IF only rises for load-use and drain/halt stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (stall_IF && (stall_cnt_q != '1))      stall_cnt_q   <= stall_cnt_q + CNT_W'(1);
      if (flush_IF_ID && (flush_cnt_q != '1))   flush_cnt_q   <= flush_cnt_q + CNT_W'(1);
      if (freeze_pipe && (memwait_cnt_q != '1)) memwait_cnt_q <= memwait_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`else
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (default parameters).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  src1_ID, src2_ID, ST_src_ID, dest_EXE;
  logic        use_src1_ID, use_src2_ID, use_st_ID;
  logic        MEM_R_EN_EXE, br_taken_EXE, halt_ID, resume, mem_req_MEM, mem_ack;
  logic        stall_IF, stall_ID, bubble_EXE, flush_IF_ID, freeze_pipe, halted, mem_err;
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(64), .DRAIN_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .ST_src_ID(ST_src_ID),
    .use_src1_ID(use_src1_ID), .use_src2_ID(use_src2_ID), .use_st_ID(use_st_ID),
    .dest_EXE(dest_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE), .br_taken_EXE(br_taken_EXE),
    .halt_ID(halt_ID), .resume(resume), .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EXE(bubble_EXE),
    .flush_IF_ID(flush_IF_ID), .freeze_pipe(freeze_pipe), .halted(halted),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .memwait_cnt(memwait_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pc(input logic [31:0] v);
    return PERF ? v : 32'd0;
  endfunction

  task automatic idle();
    src1_ID = 5'd0; src2_ID = 5'd0; ST_src_ID = 5'd0; dest_EXE = 5'd0;
    use_src1_ID = 1'b0; use_src2_ID = 1'b0; use_st_ID = 1'b0;
    MEM_R_EN_EXE = 1'b0; br_taken_EXE = 1'b0; halt_ID = 1'b0; resume = 1'b0;
    mem_req_MEM = 1'b0; mem_ack = 1'b0;
  endtask

  // Advance to the next falling edge; inputs change there, outputs are sampled 1 later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_hazard(input logic [4:0] d, input logic [4:0] s2);
    MEM_R_EN_EXE = 1'b1; dest_EXE = d; src2_ID = s2; use_src2_ID = 1'b1;
  endtask

  initial begin
    bit ok;
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_halted", halted, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_freeze", freeze_pipe, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    step(); rst_n = 1'b1;

    // Load-use on src2, then register 0, then unused source, then store source.
    step(); set_hazard(5'd5, 5'd5); settle();
    chk("lu_stall_IF", stall_IF, 1);
    chk("lu_stall_ID", stall_ID, 1);
    chk("lu_bubble", bubble_EXE, 1);
    chk("lu_flush", flush_IF_ID, 0);
    step(); idle(); settle();
    chk("lu_one_cycle", stall_IF, 0);
    step(); set_hazard(5'd0, 5'd0); settle();
    chk("lu_r0_nostall", stall_IF, 0);
    step(); set_hazard(5'd5, 5'd5); use_src2_ID = 1'b0; settle();
    chk("lu_unused_nostall", stall_ID, 0);
    step(); idle(); MEM_R_EN_EXE = 1'b1; dest_EXE = 5'd7; ST_src_ID = 5'd7; use_st_ID = 1'b1; settle();
    chk("lu_st_stall", stall_ID, 1);

    // Resume outside HALTED is ignored.
    step(); idle(); resume = 1'b1; settle();
    chk("resume_ign_stall", stall_IF, 0);
    step(); idle(); settle();
    chk("resume_ign_halted", halted, 0);

    // Branch with concurrent load-use: flush wins.
    step(); set_hazard(5'd9, 5'd9); br_taken_EXE = 1'b1; settle();
    chk("br_flush", flush_IF_ID, 1);
    chk("br_bubble", bubble_EXE, 1);
    chk("br_stall_IF", stall_IF, 0);
    step(); idle(); settle();
    chk("br_flush_cnt", flush_cnt, pc(1));
    chk("lu_stall_cnt", stall_cnt, pc(2));

    // Memory access acked after 4 frozen cycles, branch pending throughout.
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); idle(); mem_req_MEM = 1'b1; br_taken_EXE = 1'b1; settle();
      if (!(freeze_pipe === 1'b1 && flush_IF_ID === 1'b0 && bubble_EXE === 1'b0)) ok = 1'b0;
    end
    chk("mw_frozen_4", 32'(ok), 1);
    step(); idle(); mem_req_MEM = 1'b1; mem_ack = 1'b1; settle();
    chk("mw_ack_unfreeze", freeze_pipe, 0);
    step(); idle(); set_hazard(5'd3, 5'd3); settle();
    chk("mw_memwait_cnt", memwait_cnt, pc(4));
    chk("mw_back_to_run", stall_IF, 1);

    // Halt with a frozen drain cycle, then resume with HALT still in ID.
    step(); idle(); halt_ID = 1'b1; settle();
    chk("halt_c0_stall", stall_ID, 0);
    step(); settle();
    chk("drain_c1_stall", stall_IF, 1);
    chk("drain_c1_bubble", bubble_EXE, 1);
    step(); mem_req_MEM = 1'b1; settle();
    chk("drain_c2_freeze", freeze_pipe, 1);
    chk("drain_c2_nostall", stall_IF, 0);
    step(); mem_req_MEM = 1'b0; settle();
    chk("drain_c3_halted", halted, 0);
    step(); settle();
    chk("drain_c4_halted", halted, 0);
    step(); settle();
    chk("halted_c5", halted, 1);
    chk("halted_c5_stall", stall_ID, 1);
    step(); resume = 1'b1; settle();
    chk("halted_c6", halted, 1);
    step(); resume = 1'b0; settle();
    chk("resume_run_halted", halted, 0);
    chk("resume_run_stall", stall_ID, 0);
    step(); halt_ID = 1'b0; settle();
    chk("resume_no_retrigger", stall_ID, 0);
    chk("halt_stall_cnt", stall_cnt, pc(8));
    chk("halt_memwait_cnt", memwait_cnt, pc(5));
    chk("halt_flush_cnt", flush_cnt, pc(1));

    // Asynchronous reset in the middle of DRAIN.
    step(); halt_ID = 1'b1; settle();
    step(); settle();
    chk("rd_in_drain", stall_ID, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rd_halted", halted, 0);
    chk("rd_stall", stall_ID, 0);
    chk("rd_stall_cnt", stall_cnt, 0);
    chk("rd_memwait_cnt", memwait_cnt, 0);
    step(); idle(); rst_n = 1'b1;
    step(); set_hazard(5'd12, 5'd12); settle();
    chk("rd_post_lu", stall_IF, 1);

    // Memory timeout into ERR, late ack ignored.
    step(); idle(); mem_req_MEM = 1'b1; settle();
    chk("to_c0_freeze", freeze_pipe, 1);
    ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step(); settle();
      if (!(freeze_pipe === 1'b1 && mem_err === 1'b0)) ok = 1'b0;
    end
    chk("to_wait_64", 32'(ok), 1);
    step(); settle();
    chk("to_err", mem_err, 1);
    chk("to_err_freeze", freeze_pipe, 1);
    chk("to_memwait_cnt", memwait_cnt, pc(65));
    step(); mem_ack = 1'b1; br_taken_EXE = 1'b1; settle();
    chk("err_late_ack", mem_err, 1);
    chk("err_freeze_hold", freeze_pipe, 1);
    chk("err_no_flush", flush_IF_ID, 0);
    step(); idle(); settle();
    chk("err_sticky", mem_err, 1);
    rst_n = 1'b0; #1;
    chk("err_rst_clears", mem_err, 0);
    chk("err_rst_freeze", freeze_pipe, 0);
    step(); rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
